// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Brief    : SPI mode-0 target emulating the N25Q command subset used by the
//            bootloader (RDID, RDSR, WREN, WRDI, READ, PP, SE).
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
    parameter int          AW      = 8,
    parameter logic [31:0] IDCODE  = 32'h20BA1810,
    parameter int          WIP_CYC = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_cs_b_i,
    input  logic       spi_sclk_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       busy_o,
    output logic [7:0] cmd_o
);

    localparam logic [7:0] c_op_rdid = 8'h9F;
    localparam logic [7:0] c_op_rdsr = 8'h05;
    localparam logic [7:0] c_op_wren = 8'h06;
    localparam logic [7:0] c_op_wrdi = 8'h04;
    localparam logic [7:0] c_op_read = 8'h03;
    localparam logic [7:0] c_op_pp   = 8'h02;
    localparam logic [7:0] c_op_se   = 8'hD8;

    localparam int            c_depth     = 1 << AW;
    localparam int            c_wip_w     = $clog2(WIP_CYC + 1);
    localparam int            c_page_bits = (AW > 8) ? 8 : AW;
    localparam logic [AW-1:0] c_page_mask = AW'((1 << c_page_bits) - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_RESP   = 3'd3,
        S_DRD    = 3'd4,
        S_DWR    = 3'd5,
        S_DONE   = 3'd6,
        S_IGNORE = 3'd7
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]         r_cs_sync;
    logic [1:0]         r_sclk_sync;
    logic [1:0]         r_mosi_sync;
    logic               r_cs_d;
    logic               r_sclk_d;

    logic [2:0]         r_bit_cnt;
    logic [6:0]         r_sh_in;
    logic [7:0]         r_cmd;
    logic               r_wel;
    logic [1:0]         r_addr_cnt;
    logic [15:0]        r_addr_hi;
    logic [AW-1:0]      r_ptr;
    logic [7:0]         r_sh_out;
    logic               r_miso;
    logic [2:0]         r_resp_idx;
    logic               r_wr_en;
    logic [AW-1:0]      r_wr_addr;
    logic [7:0]         r_wr_data;
    logic               r_pp_written;
    logic [c_wip_w-1:0] r_wip_cnt;
    logic               r_erasing;
    logic [AW-1:0]      r_erase_addr;
    logic [7:0]         r_mem [c_depth];

    logic          w_cs_fall;
    logic          w_cs_rise;
    logic          w_sclk_rise;
    logic          w_sclk_fall;
    logic          w_mosi;
    logic          w_bit_en;
    logic          w_byte_done;
    logic [7:0]    w_byte;
    logic          w_resp_state;
    logic          w_wip;
    logic [7:0]    w_status;
    logic [AW-1:0] w_addr_new;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_rd_data;
    logic [AW-1:0] w_ptr_page_inc;
    logic [7:0]    w_id_byte;

    // Two-flop synchronizers plus one delay stage for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cs_sync   <= 2'b11;
            r_sclk_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_cs_d      <= 1'b1;
            r_sclk_d    <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], spi_cs_b_i};
            r_sclk_sync <= {r_sclk_sync[0], spi_sclk_i};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi_i};
            r_cs_d      <= r_cs_sync[1];
            r_sclk_d    <= r_sclk_sync[1];
        end
    end

    assign w_cs_fall    = !r_cs_sync[1] && r_cs_d;
    assign w_cs_rise    = r_cs_sync[1] && !r_cs_d;
    assign w_sclk_rise  = r_sclk_sync[1] && !r_sclk_d;
    assign w_sclk_fall  = !r_sclk_sync[1] && r_sclk_d;
    assign w_mosi       = r_mosi_sync[1];

    // A rise coinciding with the cs_b fall is already the first bit of the frame
    assign w_bit_en     = w_sclk_rise && !w_cs_rise && ((r_state != S_IDLE) || w_cs_fall);
    assign w_byte_done  = w_bit_en && (r_bit_cnt == 3'd7);
    assign w_byte       = {r_sh_in, w_mosi};
    assign w_resp_state = (r_state == S_RESP) || (r_state == S_DRD);
    assign w_wip        = r_erasing || (r_wip_cnt != '0);
    assign w_status     = {6'b0, r_wel, w_wip};
    assign w_addr_new   = AW'({r_addr_hi, w_byte});
    assign w_rd_addr    = (r_state == S_ADDR) ? w_addr_new : r_ptr;
    assign w_rd_data    = r_mem[w_rd_addr];
    assign w_ptr_page_inc = (r_ptr & ~c_page_mask) | ((r_ptr + 1'b1) & c_page_mask);

    always_comb begin
        w_id_byte = 8'h00;
        case (r_resp_idx)
            3'd1:    w_id_byte = IDCODE[23:16];
            3'd2:    w_id_byte = IDCODE[15:8];
            3'd3:    w_id_byte = IDCODE[7:0];
            default: w_id_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_rise) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_nxt = S_CMD;
                    end
                end
                S_CMD: begin
                    if (w_byte_done) begin
                        if (w_wip) begin
                            w_state_nxt = (w_byte == c_op_rdsr) ? S_RESP : S_IGNORE;
                        end else begin
                            case (w_byte)
                                c_op_rdid, c_op_rdsr: w_state_nxt = S_RESP;
                                c_op_wren, c_op_wrdi: w_state_nxt = S_DONE;
                                c_op_read:            w_state_nxt = S_ADDR;
                                c_op_pp, c_op_se:     w_state_nxt = r_wel ? S_ADDR : S_IGNORE;
                                default:              w_state_nxt = S_IGNORE;
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (w_byte_done && (r_addr_cnt == 2'd2)) begin
                        case (r_cmd)
                            c_op_read: w_state_nxt = S_DRD;
                            c_op_pp:   w_state_nxt = S_DWR;
                            default:   w_state_nxt = S_DONE;
                        endcase
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bit_cnt    <= 3'd0;
            r_sh_in      <= 7'd0;
            r_cmd        <= 8'h00;
            r_wel        <= 1'b0;
            r_addr_cnt   <= 2'd0;
            r_addr_hi    <= 16'd0;
            r_ptr        <= '0;
            r_sh_out     <= 8'h00;
            r_miso       <= 1'b0;
            r_resp_idx   <= 3'd0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 8'h00;
            r_pp_written <= 1'b0;
            r_wip_cnt    <= '0;
            r_erasing    <= 1'b1;
            r_erase_addr <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (r_erasing) begin
                r_erase_addr <= r_erase_addr + 1'b1;
                if (r_erase_addr == '1) begin
                    r_erasing <= 1'b0;
                end
            end
            if (r_wip_cnt != '0) begin
                r_wip_cnt <= r_wip_cnt - 1'b1;
            end

            if (w_cs_rise) begin
                r_bit_cnt  <= 3'd0;
                r_addr_cnt <= 2'd0;
                r_miso     <= 1'b0;
                r_sh_out   <= 8'h00;
                if (r_state == S_DONE && r_cmd == c_op_wren) begin
                    r_wel <= 1'b1;
                end
                if (r_state == S_DONE && r_cmd == c_op_wrdi) begin
                    r_wel <= 1'b0;
                end
                if (r_state == S_DWR) begin
                    r_wel <= 1'b0;
                    if (r_pp_written) begin
                        r_wip_cnt <= c_wip_w'(WIP_CYC);
                    end
                end
                // The whole array is a single sector
                if (r_state == S_DONE && r_cmd == c_op_se) begin
                    r_wel        <= 1'b0;
                    r_erasing    <= 1'b1;
                    r_erase_addr <= '0;
                end
            end else begin
                if (w_bit_en) begin
                    r_sh_in   <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (w_sclk_fall && w_resp_state) begin
                    r_miso   <= r_sh_out[7];
                    r_sh_out <= {r_sh_out[6:0], 1'b0};
                end
                if (w_byte_done) begin
                    case (r_state)
                        S_CMD: begin
                            r_cmd        <= w_byte;
                            r_resp_idx   <= 3'd1;
                            r_pp_written <= 1'b0;
                            r_sh_out     <= (w_byte == c_op_rdid) ? IDCODE[31:24] : w_status;
                        end
                        S_ADDR: begin
                            r_addr_hi  <= {r_addr_hi[7:0], w_byte};
                            r_addr_cnt <= r_addr_cnt + 2'd1;
                            if (r_addr_cnt == 2'd2) begin
                                if (r_cmd == c_op_read) begin
                                    r_ptr    <= w_addr_new + 1'b1;
                                    r_sh_out <= w_rd_data;
                                end else begin
                                    r_ptr <= w_addr_new;
                                end
                            end
                        end
                        S_RESP: begin
                            if (r_cmd == c_op_rdid) begin
                                r_sh_out <= w_id_byte;
                                if (r_resp_idx != 3'd4) begin
                                    r_resp_idx <= r_resp_idx + 3'd1;
                                end
                            end else begin
                                r_sh_out <= w_status;
                            end
                        end
                        S_DRD: begin
                            r_sh_out <= w_rd_data;
                            r_ptr    <= r_ptr + 1'b1;
                        end
                        S_DWR: begin
                            r_wr_en      <= 1'b1;
                            r_wr_addr    <= r_ptr;
                            r_wr_data    <= w_byte;
                            r_ptr        <= w_ptr_page_inc;
                            r_pp_written <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Erase and program never overlap: PP is refused while WIP is set
    always_ff @(posedge clk_i) begin
        if (r_erasing) begin
            r_mem[r_erase_addr] <= 8'hFF;
        end else if (r_wr_en) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
    end

    assign spi_miso_o = r_miso && w_resp_state;
    assign busy_o     = w_wip;
    assign cmd_o      = r_cmd;

endmodule
`default_nettype wire
